// File: rtl/pulse_period_meter_pkg.sv
// ============================================================================
// Module      : pulse_period_meter_pkg
// Description : Shared types for the pulse period meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_period_meter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } meas_state_e;

endpackage : pulse_period_meter_pkg

`default_nettype wire

// File: rtl/pulse_period_meter_sync_edge_detect.sv
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchronizer for an async input plus rise/fall detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule : sync_edge_detect

`default_nettype wire

// File: rtl/pulse_period_meter.sv
// ============================================================================
// Module      : pulse_period_meter
// Description : Measures period and high time of an async signal in clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_sig   (i_sig),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hlatch_q, hlatch_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            hlatch_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            hlatch_q  <= hlatch_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        hlatch_d  = hlatch_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                // A rise on the saturating cycle still yields a valid measurement.
                if (w_rise) begin
                    period_d  = cnt_q;
                    high_d    = hlatch_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (w_level) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                    if (w_fall) begin
                        hlatch_d = hcnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule : pulse_period_meter

`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
// ============================================================================
// Module      : tb_pulse_period_meter
// Description : Self-checking bench for pulse_period_meter (CNT_W=6 build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_period_meter;

    localparam int W    = 6;
    localparam int S    = 2;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sig = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         tmo;

    pulse_period_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (S)
    ) dut (
        .i_clk     (clk),
        .rst       (rst),
        .i_sig     (sig),
        .o_period  (period),
        .o_high    (high),
        .o_valid   (valid),
        .o_timeout (tmo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         v;
        logic         t;
        logic [W-1:0] p;
        logic [W-1:0] h;
    } out_t;

    // Event-level model: works on the per-cycle samples of i_sig, measuring
    // distances between sampled rising edges; results surface S cycles later.
    out_t pipe [0:S];
    out_t m;
    int   k;
    int   lastrise;
    int   hcount;
    bit   prev_s;
    bit   locked;
    bit   s;

    always @(posedge clk) begin
        if (rst) begin
            m        = '0;
            k        = 0;
            lastrise = 0;
            hcount   = 0;
            prev_s   = 1'b0;
            locked   = 1'b0;
            for (int i = 0; i <= S; i++) pipe[i] = '0;
        end else begin
            s   = sig;
            m.v = 1'b0;
            if (s && !prev_s) begin
                if (locked) begin
                    m.v = 1'b1;
                    m.p = W'(k - lastrise);
                    m.h = W'(hcount);
                    m.t = 1'b0;
                end
                locked   = 1'b1;
                lastrise = k;
                hcount   = 1;
            end else if (locked) begin
                if (s) hcount++;
                if (k - lastrise == MAXC) begin
                    m.t    = 1'b1;
                    locked = 1'b0;
                end
            end
            prev_s = s;
            k++;
            for (int i = S; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = m;
        end
    end

    int nvalid    = 0;
    int cyc       = 0;
    int lastv_cyc = 0;
    int tdelay    = -1;
    bit tmo_prev  = 1'b0;
    bit async_chk = 1'b0;

    always @(negedge clk) begin
        out_t e;
        out_t g;
        e = rst ? '0 : pipe[S];
        g = {valid, tmo, period, high};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got v=%b to=%b p=%0d h=%0d, want v=%b to=%b p=%0d h=%0d",
                     $time, g.v, g.t, g.p, g.h, e.v, e.t, e.p, e.h);
        end
        if (valid === 1'b1) begin
            nvalid++;
            lastv_cyc = cyc;
            if (async_chk) begin
                checks++;
                if (!(period == 13 || period == 14)) begin
                    errors++;
                    $display("FAIL async_period t=%0t: got %0d, want 13 or 14", $time, period);
                end
            end
        end
        if (tmo === 1'b1 && !tmo_prev) tdelay = cyc - lastv_cyc;
        tmo_prev = (tmo === 1'b1);
        cyc++;
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic drive(input int n, input int h, input int periods);
        for (int p = 0; p < periods; p++)
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                sig = (c < h);
            end
    endtask

    task automatic hold(input int cycles, input bit lvl);
        repeat (cycles) begin
            @(negedge clk);
            sig = lvl;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int  n0;
        longint t0;
        longint tr;
        longint tf;

        hold(3, 1'b0);
        #3 rst = 1'b0;
        hold(2, 1'b0);
        check("reset_state", int'({valid, tmo, period, high}), 0);

        hold(100, 1'b0);
        check("stuck_low_no_timeout", int'(tmo), 0);

        n0 = nvalid;
        drive(10, 5, 8);
        check("sq10_valid_count", nvalid - n0, 7);
        check("sq10_period", int'(period), 10);
        check("sq10_high", int'(high), 5);

        drive(20, 3, 5);
        check("duty_period", int'(period), 20);
        check("duty_high", int'(high), 3);

        drive(2, 1, 10);
        check("min_period", int'(period), 2);
        check("min_high", int'(high), 1);

        drive(8, 4, 4);
        hold(10, 1'b0);
        n0 = nvalid;
        hold(70, 1'b0);
        check("timeout_set", int'(tmo), 1);
        check("timeout_delay", tdelay, MAXC);
        check("timeout_period_held", int'(period), 8);
        check("timeout_no_valid", nvalid - n0, 0);
        drive(8, 4, 1);
        check("timeout_after_first_rise", int'(tmo), 1);
        drive(8, 4, 2);
        check("timeout_cleared", int'(tmo), 0);
        check("restart_period", int'(period), 8);

        drive(10, 5, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset_outputs", int'({valid, tmo, period, high}), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        n0 = nvalid;
        drive(10, 5, 1);
        check("post_reset_first_rise", nvalid - n0, 0);
        drive(10, 5, 2);
        check("post_reset_valids", nvalid - n0, 2);
        check("post_reset_period", int'(period), 10);

        sig = 1'b0;
        pulse_reset();
        hold(5, 1'b0);
        n0 = nvalid;
        async_chk = 1'b1;
        t0 = $time + 2;
        for (int n = 0; n < 12; n++) begin
            tr = t0 + (longint'(n) * 400) / 3 + longint'($urandom_range(0, 3));
            if (tr % 10 == 5) tr = tr + 1;
            tf = tr + 65;
            if (tf % 10 == 5) tf = tf + 1;
            #(tr - $time) sig = 1'b1;
            #(tf - $time) sig = 1'b0;
        end
        hold(20, 1'b0);
        async_chk = 1'b0;
        check("async_valid_count", nvalid - n0, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t: got timeout, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pulse_period_meter

`default_nettype wire
